// File: rtl/pc_stack_if.sv
// rtl/pc_stack_if.sv - control/target bundle and PC/stack status for pc_stack
interface pc_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in;
    logic             load;
    logic             rel;
    logic             inc;
    logic             call;
    logic             ret;
    logic             stall;
    logic             clr_err;
    logic [WIDTH-1:0] out;
    logic [SPW-1:0]   sp;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output in, load, rel, inc, call, ret, stall, clr_err,
        input  out, sp, empty, full, overflow, underflow
    );

    modport slave (
        input  in, load, rel, inc, call, ret, stall, clr_err,
        output out, sp, empty, full, overflow, underflow
    );
endinterface

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with return-address stack and sticky stack-error flags
module pc_stack #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    localparam int              SPW       = $clog2(DEPTH + 1)
) (
    input  logic        clock,
    input  logic        reset,
    pc_stack_if.slave   bus
);
    localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] FULL_SP = SPW'(DEPTH);

    logic [WIDTH-1:0] pc_q;
    logic [SPW-1:0]   sp_q;
    logic             ovf_q;
    logic             unf_q;
    logic [WIDTH-1:0] stack_mem [DEPTH];

    logic             is_empty;
    logic             is_full;
    logic             act_ret;
    logic             act_call;
    logic             push;
    logic             set_ovf;
    logic             set_unf;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] ret_addr;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == FULL_SP);

    // ret outranks call, so a simultaneous call is simply ignored.
    assign act_ret  = ~bus.stall & bus.ret;
    assign act_call = ~bus.stall & ~bus.ret & bus.call;
    assign push     = act_call & ~is_full;
    assign set_ovf  = act_call & is_full;
    assign set_unf  = act_ret & is_empty;

    assign wr_idx   = AW'(sp_q);
    assign rd_idx   = AW'(sp_q - 1'b1);
    assign ret_addr = stack_mem[rd_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VEC;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.ret) begin
                if (!is_empty) begin
                    pc_q <= ret_addr;
                    sp_q <= sp_q - 1'b1;
                end
            end else if (bus.call) begin
                if (!is_full) begin
                    pc_q <= bus.in;
                    sp_q <= sp_q + 1'b1;
                end
            end else if (bus.load) begin
                pc_q <= bus.in;
            end else if (bus.rel) begin
                pc_q <= pc_q + bus.in;
            end else if (bus.inc) begin
                pc_q <= pc_q + 1'b1;
            end
            // A flag raised on the same edge as clr_err stays set.
            ovf_q <= (ovf_q & ~bus.clr_err) | set_ovf;
            unf_q <= (unf_q & ~bus.clr_err) | set_unf;
        end
    end

    // Stack storage is never reset; only entries below sp are meaningful.
    always_ff @(posedge clock) begin
        if (reset && push) begin
            stack_mem[wr_idx] <= pc_q + 1'b1;
        end
    end

    assign bus.out       = pc_q;
    assign bus.sp        = sp_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - vector table, corner sequences and randomized model check for pc_stack
module tb_pc_stack;
    localparam int          WIDTH = 16;
    localparam int          DEPTH = 4;
    localparam int unsigned MOD   = 65536;

    localparam logic [6:0] C_STALL = 7'h40;
    localparam logic [6:0] C_RET   = 7'h20;
    localparam logic [6:0] C_CALL  = 7'h10;
    localparam logic [6:0] C_LOAD  = 7'h08;
    localparam logic [6:0] C_REL   = 7'h04;
    localparam logic [6:0] C_INC   = 7'h02;
    localparam logic [6:0] C_CLR   = 7'h01;
    localparam logic [6:0] C_ALL   = 7'h7F;

    typedef struct {
        logic [6:0]  c;
        logic [15:0] d;
        logic [15:0] eo;
        int          esp;
        logic        eov;
        logic        eun;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    vec_t        vecs[$];
    int unsigned stk[$];
    int unsigned m_pc;
    logic        m_ovf;
    logic        m_unf;

    pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VEC(16'h0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit (actual=timeout required=finish)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] c, input logic [15:0] d);
        bus.stall   = c[6];
        bus.ret     = c[5];
        bus.call    = c[4];
        bus.load    = c[3];
        bus.rel     = c[2];
        bus.inc     = c[1];
        bus.clr_err = c[0];
        bus.in      = d;
    endtask

    task automatic model_reset();
        stk.delete();
        m_pc  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step();
        logic so, su;
        so = 1'b0;
        su = 1'b0;
        if (bus.stall) return;
        if (bus.ret) begin
            if (stk.size() > 0) m_pc = stk.pop_back();
            else su = 1'b1;
        end else if (bus.call) begin
            if (stk.size() < DEPTH) begin
                stk.push_back((m_pc + 1) % MOD);
                m_pc = bus.in;
            end else begin
                so = 1'b1;
            end
        end else if (bus.load) begin
            m_pc = bus.in;
        end else if (bus.rel) begin
            m_pc = (m_pc + bus.in) % MOD;
        end else if (bus.inc) begin
            m_pc = (m_pc + 1) % MOD;
        end
        if (bus.clr_err) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        m_ovf = m_ovf | so;
        m_unf = m_unf | su;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic check_state(input string tag, input logic [15:0] eo, input int esp,
                               input logic eov, input logic eun);
        check({tag, " out"},       32'(bus.out),       32'(eo));
        check({tag, " sp"},        32'(bus.sp),        32'(esp));
        check({tag, " empty"},     32'(bus.empty),     32'(esp == 0));
        check({tag, " full"},      32'(bus.full),      32'(esp == DEPTH));
        check({tag, " overflow"},  32'(bus.overflow),  32'(eov));
        check({tag, " underflow"}, 32'(bus.underflow), 32'(eun));
    endtask

    task automatic check_model(input string tag);
        check_state(tag, 16'(m_pc), stk.size(), m_ovf, m_unf);
    endtask

    task automatic add(input logic [6:0] c, input logic [15:0] d, input logic [15:0] eo,
                       input int esp, input logic eov, input logic eun);
        vec_t v;
        v.c = c; v.d = d; v.eo = eo; v.esp = esp; v.eov = eov; v.eun = eun;
        vecs.push_back(v);
    endtask

    initial begin
        drive(7'h00, 16'h0000);
        model_reset();

        add(C_INC, 16'h0, 16'd1, 0, 0, 0);
        add(C_INC, 16'h0, 16'd2, 0, 0, 0);
        add(C_INC, 16'h0, 16'd3, 0, 0, 0);
        add(C_INC, 16'h0, 16'd4, 0, 0, 0);
        add(C_INC, 16'h0, 16'd5, 0, 0, 0);
        add(C_LOAD, 16'hFFFE, 16'hFFFE, 0, 0, 0);
        add(C_INC, 16'h0, 16'hFFFF, 0, 0, 0);
        add(C_INC, 16'h0, 16'h0000, 0, 0, 0);
        add(C_LOAD, 16'd100, 16'd100, 0, 0, 0);
        add(C_REL, 16'hFFF6, 16'd90, 0, 0, 0);
        add(C_LOAD | C_INC | C_REL, 16'd7, 16'd7, 0, 0, 0);
        add(C_LOAD, 16'd10, 16'd10, 0, 0, 0);
        add(C_CALL, 16'd100, 16'd100, 1, 0, 0);
        add(C_CALL, 16'd200, 16'd200, 2, 0, 0);
        add(C_RET, 16'h0, 16'd101, 1, 0, 0);
        add(C_RET, 16'h0, 16'd11, 0, 0, 0);
        add(C_LOAD, 16'd39, 16'd39, 0, 0, 0);
        add(C_CALL, 16'd5, 16'd5, 1, 0, 0);
        add(C_RET | C_CALL, 16'd77, 16'd40, 0, 0, 0);
        add(C_ALL, 16'd123, 16'd40, 0, 0, 0);
        add(C_LOAD, 16'd0, 16'd0, 0, 0, 0);
        add(C_CALL, 16'd10, 16'd10, 1, 0, 0);
        add(C_CALL, 16'd20, 16'd20, 2, 0, 0);
        add(C_CALL, 16'd30, 16'd30, 3, 0, 0);
        add(C_CALL, 16'd40, 16'd40, 4, 0, 0);
        add(C_CALL, 16'd50, 16'd40, 4, 1, 0);
        add(C_ALL, 16'd99, 16'd40, 4, 1, 0);
        add(C_RET, 16'h0, 16'd31, 3, 1, 0);
        add(C_RET, 16'h0, 16'd21, 2, 1, 0);
        add(C_RET, 16'h0, 16'd11, 1, 1, 0);
        add(C_RET, 16'h0, 16'd1, 0, 1, 0);
        add(C_RET, 16'h0, 16'd1, 0, 1, 1);
        add(C_CLR, 16'h0, 16'd1, 0, 0, 0);
        add(C_RET | C_CLR, 16'h0, 16'd1, 0, 0, 1);
        add(C_CLR, 16'h0, 16'd1, 0, 0, 0);
        add(C_REL, 16'hFFFF, 16'd0, 0, 0, 0);
        add(C_INC, 16'h0, 16'd1, 0, 0, 0);
        add(7'h00, 16'h0, 16'd1, 0, 0, 0);

        #2;
        check_state("reset async", 16'h0000, 0, 1'b0, 1'b0);
        #10;
        check_state("reset held", 16'h0000, 0, 1'b0, 1'b0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].c, vecs[i].d);
            step();
            check_state($sformatf("vec%0d", i), vecs[i].eo, vecs[i].esp, vecs[i].eov, vecs[i].eun);
        end

        drive(C_LOAD, 16'h0050); step();
        drive(C_CALL, 16'h0060); step();
        drive(C_CALL, 16'h0070); step();
        check_model("pre-reset two calls");
        check("pre-reset sp", 32'(bus.sp), 32'd2);
        drive(7'h00, 16'h0000);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_state("mid reset", 16'h0000, 0, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        drive(C_RET, 16'h0000); step();
        check_state("ret after reset", 16'h0000, 0, 1'b0, 1'b1);

        for (int n = 0; n < 400; n++) begin
            logic [6:0] c;
            c[6] = ($urandom_range(0, 99) < 10);
            c[5] = ($urandom_range(0, 99) < 22);
            c[4] = ($urandom_range(0, 99) < 28);
            c[3] = ($urandom_range(0, 99) < 15);
            c[2] = ($urandom_range(0, 99) < 15);
            c[1] = ($urandom_range(0, 99) < 40);
            c[0] = ($urandom_range(0, 99) < 10);
            drive(c, 16'($urandom));
            step();
            check_model($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with a hardware return-address stack: the next-generation successor to the 16-bit load/inc/reset PC. It sits in the CPU fetch stage and drives the instruction-memory address. It adds configurable width, PC-relative branches, call/return via an internal LIFO of configurable depth, a stall input, and sticky stack-error flags.

## Interface
- WIDTH, 16: PC and address width in bits.
- DEPTH, 8: return-stack entries (≥1).
- RESET_VEC, 0: value loaded into out on reset.
- SPW, $clog2(DEPTH+1): stack-pointer width (derived, not overridden).

- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- in  input  WIDTH  absolute target (load, call) or signed offset (rel).
- load  input  1  out ← in.
- rel  input  1  out ← out + in (two's complement).
- inc  input  1  out ← out + 1.
- call  input  1  push out+1, out ← in.
- ret  input  1  pop top into out.
- stall  input  1  freeze all state.
- clr_err  input  1  clear sticky error flags.
- out  output  WIDTH  current PC, registered.
- sp  output  SPW  number of valid stack entries, 0..DEPTH.
- empty  output  1  sp == 0.
- full  output  1  sp == DEPTH.
- overflow  output  1  sticky: call attempted while full.
- underflow  output  1  sticky: ret attempted while empty.

## Operation
- Reset (reset=0, any time, independent of clock): out=RESET_VEC, sp=0, overflow=0, underflow=0, empty=1, full=0. Stack RAM contents are don't-care and are not cleared.
- Per rising edge with reset=1, exactly one action is taken, in fixed priority: stall > ret > call > load > rel > inc > hold.
  - stall: nothing changes, including flags. clr_err is ignored.
  - ret, sp>0: out ← stack[sp-1], sp ← sp-1.
  - ret, sp==0: out unchanged, sp unchanged, underflow ← 1.
  - call, sp<DEPTH: stack[sp] ← out+1, sp ← sp+1, out ← in.
  - call, sp==DEPTH: out unchanged, no push, overflow ← 1. The call is dropped, not redirected.
  - load: out ← in.
  - rel: out ← out + in, both WIDTH bits, result mod 2^WIDTH.
  - inc: out ← out + 1 mod 2^WIDTH. 2^WIDTH−1 wraps to 0.
  - none asserted: hold.
- clr_err (not stalled) clears overflow and underflow on that edge. If the same edge sets a flag, the set wins.
- Return address pushed = out+1 (mod 2^WIDTH) of the calling cycle.
- full/empty are combinational from sp.

## Timing
- Single-cycle: a control asserted before edge k is reflected on out, sp, and flags after edge k. There is no pipelining.
- Back-to-back call/ret on consecutive cycles is legal. A ret the cycle after a call returns the address just pushed.
- Controls and in must be stable around the rising edge. Deasserting reset is synchronous to operation: the first action occurs on the first rising edge with reset=1.
- Reset asserted mid-sequence (for example, between a call and its ret) discards the stack. A subsequent ret underflows.

## Test plan
- Reset/inc: reset=0 for 10 ns, then inc=1 for 5 edges → out 0,1,2,3,4,5; sp=0, empty=1. Assert reset=0 between edges → out=0 immediately, without waiting for an edge.
- Load/rel/wrap (WIDTH=16): load in=16'hFFFE; inc twice → FFFF, then 0000. load in=100, then rel in=16'hFFF6 (−10) → out=90.
- Priority: in=7 with load=inc=rel=1 → out=7. With ret=1 and call=1, sp=1, top=40 → out=40, sp=0. With stall=1 and every other control high → all outputs unchanged.
- Call/return nesting (DEPTH=4): out=10, call in=100; at 100, call in=200; ret → out=101, sp=1; ret → out=11, sp=0, empty=1.
- Overflow (DEPTH=4): five calls from out=0 with in=10,20,30,40,50. After the fourth call full=1, out=40. The fifth leaves out=40, sp=4, overflow=1. Four rets → 31,21,11,1. A fifth ret → out=1, underflow=1. clr_err → both flags 0.
- Async reset mid-operation: two calls (sp=2), then pulse reset=0 off-edge → out=RESET_VEC, sp=0, flags 0. ret → underflow=1, out unchanged.
